// File: rtl/bsg_test_node_client.sv
// bsg_test_node_client
//   Client end of the FSB trace-replay test link. Accepts command packets
//   from the master node, executes them against a small local register
//   file and returns response packets through a 2-entry registered FIFO.
//
// Ports
//   clk_i, reset_i   clock, asynchronous active-high reset
//   en_i             node enable; low blocks new commands
//   v_i/data_i       command packet in, handshake with ready_o
//   v_o/data_o       response packet out, consumed by yumi_i
//   done_o           sticky, FINISH command seen
//   error_o          sticky, bad opcode or out-of-range address seen
//
// Packet layout, MSB first (R = ring_width_p):
//   dest[R-1-:4] src[R-5-:4] op[R-9-:4] addr[R-13-:8] rsvd[R-21:32] data[31:0]
module bsg_test_node_client #(
  parameter int         ring_width_p = 80,
  parameter logic [3:0] master_id_p  = 4'h0,
  parameter logic [3:0] client_id_p  = 4'h1,
  parameter int         els_p        = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic                    done_o,
  output logic                    error_o
);

  localparam int         R        = ring_width_p;
  localparam int         idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [8:0] els_lp   = 9'(els_p);

  localparam logic [3:0] OP_WRITE  = 4'd0;
  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_ECHO   = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_FINISH = 4'd4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_s;

  cmd_s                cmd;
  logic                accept, hit, addr_ok, push, pop;
  logic [idx_w_lp-1:0] idx;
  logic [31:0]         rf_rdata, result;
  logic [R-1:0]        resp;
  logic [1:0]          cnt_after_pop;

  logic [1:0]   count_q, count_d;
  logic [R-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [31:0]  rf_q [els_p];
  logic [31:0]  rf_d [els_p];
  logic         done_q, done_d, error_q, error_d;

  // src and the reserved field carry nothing this node acts on
  logic unused_bits;
  assign unused_bits = ^{cmd.src, data_i};

  always_comb begin
    cmd.dest = data_i[R-1  -: 4];
    cmd.src  = data_i[R-5  -: 4];
    cmd.op   = data_i[R-9  -: 4];
    cmd.addr = data_i[R-13 -: 8];
    cmd.data = data_i[31:0];
  end

  // Gated on the pre-pop count: a full FIFO never accepts, even with yumi_i
  assign ready_o  = en_i & ~reset_i & (count_q < 2'd2);
  assign accept   = v_i & ready_o;
  assign hit      = accept & (cmd.dest == client_id_p);
  assign addr_ok  = {1'b0, cmd.addr} < els_lp;
  assign idx      = cmd.addr[idx_w_lp-1:0];
  assign rf_rdata = rf_q[idx];

  // Command execution
  always_comb begin
    rf_d    = rf_q;
    done_d  = done_q;
    error_d = error_q;
    push    = 1'b0;
    result  = '0;
    if (hit) begin
      case (cmd.op)
        OP_WRITE: begin
          if (addr_ok) rf_d[idx] = cmd.data;
          else         error_d   = 1'b1;
        end
        OP_READ: begin
          push = 1'b1;
          if (addr_ok) result  = rf_rdata;
          else         error_d = 1'b1;
        end
        OP_ECHO: begin
          push   = 1'b1;
          result = cmd.data;
        end
        OP_ADD: begin
          push = 1'b1;
          if (addr_ok) begin
            result    = rf_rdata + cmd.data;
            rf_d[idx] = result;
          end else begin
            error_d = 1'b1;
          end
        end
        OP_FINISH: done_d = 1'b1;
        default:   error_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    resp           = '0;
    resp[R-1  -: 4] = master_id_p;
    resp[R-5  -: 4] = client_id_p;
    resp[R-9  -: 4] = cmd.op;
    resp[R-13 -: 8] = cmd.addr;
    resp[31:0]      = result;
  end

  // Response FIFO: shift register, slot0 is the head. Pop first, then the
  // push lands in the first free slot, so push+pop at count 1 keeps order.
  assign pop = yumi_i & (count_q != 2'd0);

  always_comb begin
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    cnt_after_pop = count_q;
    if (pop) begin
      slot0_d       = slot1_q;
      slot1_d       = '0;
      cnt_after_pop = count_q - 2'd1;
    end
    if (push) begin
      if (cnt_after_pop == 2'd0) slot0_d = resp;
      else                       slot1_d = resp;
    end
    count_d = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      for (int i = 0; i < els_p; i++) rf_q[i] <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      done_q  <= done_d;
      error_q <= error_d;
      for (int i = 0; i < els_p; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign v_o     = (count_q != 2'd0);
  assign data_o  = slot0_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_bsg_test_node_client.sv
// Bench for bsg_test_node_client: table of single commands checked through a
// response scoreboard, plus hand sequences for latency, back-to-back traffic,
// FIFO backpressure, finish, enable gating and async reset.
module tb_bsg_test_node_client;

  localparam int R = 80;

  logic         clk = 1'b0;
  logic         reset_i, en_i, v_i, yumi_i;
  logic [R-1:0] data_i;
  logic         ready_o, v_o, done_o, error_o;
  logic [R-1:0] data_o;

  always #5 clk = ~clk;

  bsg_test_node_client #(
    .ring_width_p(R), .master_id_p(4'h0), .client_id_p(4'h1), .els_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .done_o(done_o), .error_o(error_o)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [R-1:0] sb[$];
  logic [R-1:0] mon_exp;

  typedef struct {
    logic [3:0]  dest;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [31:0] d;
    bit          resp;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t vt[18];

  function automatic logic [R-1:0] mk_cmd(input logic [3:0] dest, input logic [3:0] op,
                                          input logic [7:0] addr, input logic [31:0] d);
    logic [R-1:0] p;
    p           = '0;
    p[R-1  -: 4] = dest;
    p[R-5  -: 4] = 4'h0;
    p[R-9  -: 4] = op;
    p[R-13 -: 8] = addr;
    p[R-21 : 32] = {7{4'hA}};  // junk in reserved bits must be ignored
    p[31:0]      = d;
    return p;
  endfunction

  function automatic logic [R-1:0] mk_resp(input logic [3:0] op, input logic [7:0] addr,
                                           input logic [31:0] d);
    logic [R-1:0] p;
    p           = '0;
    p[R-1  -: 4] = 4'h0;
    p[R-5  -: 4] = 4'h1;
    p[R-9  -: 4] = op;
    p[R-13 -: 8] = addr;
    p[31:0]      = d;
    return p;
  endfunction

  task automatic check(input string nm, input logic [R-1:0] act, input logic [R-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare the head whenever the master consumes a response
  always @(negedge clk) begin
    if (!reset_i && v_o && yumi_i) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got %h want none", data_o);
      end else begin
        mon_exp = sb.pop_front();
        check("resp", data_o, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a packet until accepted (bounded); returns at posedge+1 after accept
  task automatic send(input logic [R-1:0] pkt, input string nm);
    int t;
    t      = 0;
    v_i    = 1'b1;
    data_i = pkt;
    #1;
    while (!ready_o && t < 30) begin
      step();
      #1;
      t++;
    end
    if (!ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: ready_o 0 want 1", nm);
      v_i = 1'b0;
    end else begin
      step();
      v_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'h1, 4'h0, 8'h03, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{4'h1, 4'h1, 8'h03, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{4'h1, 4'h0, 8'h05, 32'h2,        1'b0, 32'h0,        1'b0};
    vt[3]  = '{4'h1, 4'h3, 8'h05, 32'hFFFFFFFF, 1'b1, 32'h1,        1'b0};
    vt[4]  = '{4'h1, 4'h3, 8'h05, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0};
    vt[5]  = '{4'h1, 4'h2, 8'hAA, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
    vt[6]  = '{4'h7, 4'h0, 8'h03, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[7]  = '{4'h7, 4'h1, 8'h03, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[8]  = '{4'h1, 4'h1, 8'h03, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[9]  = '{4'h1, 4'h0, 8'h0F, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    vt[10] = '{4'h1, 4'h1, 8'h0F, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vt[11] = '{4'h1, 4'h3, 8'h0F, 32'h1,        1'b1, 32'hCAFEF00E, 1'b0};
    vt[12] = '{4'h1, 4'h1, 8'h14, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[13] = '{4'h1, 4'h9, 8'h03, 32'h77,       1'b0, 32'h0,        1'b1};
    vt[14] = '{4'h1, 4'h0, 8'h10, 32'h5555,     1'b0, 32'h0,        1'b1};
    vt[15] = '{4'h1, 4'h3, 8'hFF, 32'h5,        1'b1, 32'h0,        1'b1};
    vt[16] = '{4'h1, 4'h1, 8'h03, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};
    vt[17] = '{4'h1, 4'h1, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1};

    // Reset state, with a command already offered
    reset_i = 1'b1; en_i = 1'b1; yumi_i = 1'b0;
    v_i = 1'b1; data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h1);
    step(); step();
    check("rst_ready", ready_o, 0);
    check("rst_v", v_o, 0);
    check("rst_data", data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    v_i = 1'b0; reset_i = 1'b0; yumi_i = 1'b1;
    #1;
    check("post_rst_ready", ready_o, 1);
    step();

    // Table: one command at a time, responses drained through the scoreboard
    for (int i = 0; i < 18; i++) begin
      if (vt[i].resp) sb.push_back(mk_resp(vt[i].op, vt[i].addr, vt[i].rd));
      send(mk_cmd(vt[i].dest, vt[i].op, vt[i].addr, vt[i].d), "vec");
      step(); step();
      check($sformatf("vec%0d_error", i), error_o, vt[i].err);
      check($sformatf("vec%0d_v_idle", i), v_o, 0);
    end

    // Response appears the cycle after the READ is accepted
    sb.push_back(mk_resp(4'h1, 8'h03, 32'hDEADBEEF));
    v_i = 1'b1; data_i = mk_cmd(4'h1, 4'h1, 8'h03, 32'h0);
    #1;
    check("lat_ready", ready_o, 1);
    check("lat_v_before", v_o, 0);
    step();
    v_i = 1'b0;
    check("lat_v_after", v_o, 1);
    check("lat_data", data_o, mk_resp(4'h1, 8'h03, 32'hDEADBEEF));
    step(); step();

    // Back-to-back ECHOs with yumi high: push and pop in the same cycle
    for (int i = 0; i < 3; i++) sb.push_back(mk_resp(4'h2, 8'h00, 32'h40 + i));
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h40 + i);
      #1;
      check("b2b_ready", ready_o, 1);
      step();
    end
    v_i = 1'b0;
    step(); step();

    // Backpressure: two accepted, third held until the head is popped
    yumi_i = 1'b0;
    sb.push_back(mk_resp(4'h2, 8'h00, 32'h11));
    sb.push_back(mk_resp(4'h2, 8'h00, 32'h22));
    sb.push_back(mk_resp(4'h2, 8'h00, 32'h33));
    v_i = 1'b1; data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h11);
    #1; check("bp_ready0", ready_o, 1);
    step();
    data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h22);
    #1; check("bp_ready1", ready_o, 1);
    step();
    data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h33);
    #1;
    check("bp_full_ready", ready_o, 0);
    check("bp_full_v", v_o, 1);
    check("bp_head", data_o, mk_resp(4'h2, 8'h00, 32'h11));
    step();
    check("bp_hold", data_o, mk_resp(4'h2, 8'h00, 32'h11));
    yumi_i = 1'b1;
    #1; check("bp_full_yumi_ready", ready_o, 0);
    step();
    yumi_i = 1'b0;
    #1; check("bp_after_pop_ready", ready_o, 1);
    step();
    v_i = 1'b0;
    check("bp_head2", data_o, mk_resp(4'h2, 8'h00, 32'h22));
    yumi_i = 1'b1;
    step(); step(); step();

    // FINISH: sticky done, no response, traffic continues
    check("done_before", done_o, 0);
    send(mk_cmd(4'h1, 4'h4, 8'h00, 32'h0), "finish");
    check("done_after", done_o, 1);
    check("finish_noresp", v_o, 0);
    sb.push_back(mk_resp(4'h2, 8'h01, 32'hD0));
    send(mk_cmd(4'h1, 4'h2, 8'h01, 32'hD0), "echo_after_done");
    step(); step();
    check("done_sticky", done_o, 1);

    // Enable low: nothing accepted
    en_i = 1'b0;
    v_i = 1'b1; data_i = mk_cmd(4'h1, 4'h2, 8'h00, 32'h99);
    #1; check("en_low_ready", ready_o, 0);
    step(); step();
    v_i = 1'b0; en_i = 1'b1;
    step();

    // Async reset with two responses queued
    yumi_i = 1'b0;
    send(mk_cmd(4'h1, 4'h2, 8'h00, 32'hA1), "q0");
    send(mk_cmd(4'h1, 4'h2, 8'h00, 32'hA2), "q1");
    check("q_full_v", v_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_v", v_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_data", data_o, 0);
    check("arst_done", done_o, 0);
    check("arst_error", error_o, 0);
    step(); step();
    reset_i = 1'b0; yumi_i = 1'b1;
    sb.push_back(mk_resp(4'h1, 8'h03, 32'h0));
    send(mk_cmd(4'h1, 4'h1, 8'h03, 32'h0), "read_after_rst");
    step(); step(); step();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_test_node_client.md
Name: bsg_test_node_client

Overview:
- Client end of the FSB trace-replay test link.
- Accepts command packets from a trace-replaying master node, executes them against a small local register file, and returns response packets to the master.
- Sits on the ring opposite the master node in bench and tapeout loopback configurations.
- Drives `done_o` when the master sends a finish command.

Parameters:
- ring_width_p, 80, packet width; must be >= 52.
- master_id_p, 0, 4-bit node id placed in the dest field of responses.
- client_id_p, 1, 4-bit node id this client answers to.
- els_p, 16, register file entries (32-bit each); power of two, <= 256.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- en_i  in  1  node enable; when low no packets are accepted.
- v_i  in  1  command packet valid.
- data_i  in  ring_width_p  command packet.
- ready_o  out  1  client can accept a packet this cycle (valid/ready handshake).
- v_o  out  1  response packet valid.
- data_o  out  ring_width_p  response packet.
- yumi_i  in  1  master consumes response (late, only when v_o=1).
- done_o  out  1  sticky, finish command received.
- error_o  out  1  sticky, bad opcode or out-of-range address seen.

Behaviour:
- Packet fields, MSB first:
  - dest[R-1 -: 4]
  - src[R-5 -: 4]
  - op[R-9 -: 4]
  - addr[R-13 -: 8]
  - reserved[R-21 : 32], ignored on input, zero on output
  - data[31:0]
  - (R = ring_width_p)
- Accept = v_i & ready_o.
- ready_o = en_i & ~reset_i & (response FIFO count < 2). Gated on count before any same-cycle pop, so a full FIFO never accepts even while yumi_i is high.
- dest != client_id_p: packet consumed and dropped; no response, no state change, no error.
- Opcodes (addr valid iff addr < els_p):
  - 0 WRITE: rf[addr] <= data; no response.
  - 1 READ: response data = rf[addr].
  - 2 ECHO: response data = data_i data; addr ignored.
  - 3 ADD: rf[addr] <= rf[addr] + data, mod 2^32; response carries the new value.
  - 4 FINISH: done_o <= 1 next cycle; no response.
  - Other opcodes: error_o <= 1; packet dropped; no response.
- Out-of-range addr on WRITE/READ/ADD: error_o <= 1; no register update. READ/ADD still respond, with data 0.
- Response packet = {master_id_p, client_id_p, op, addr, zeros, result}.
- Response FIFO: 2 entries, registered. A packet accepted in cycle N is visible on v_o/data_o in cycle N+1 at the earliest.
  - yumi_i pops the head.
  - Push and pop in the same cycle are allowed when count is 1.
  - Order is preserved.
  - data_o holds steady while v_o=1 and yumi_i=0.
- Register file: written on accept edge. READ immediately after WRITE to the same addr returns the new value (the write was committed on the prior edge).
- done_o and error_o are sticky until reset. done_o does not block further traffic.
- Reset (async assert, any time, including mid-packet or with FIFO occupied):
  - v_o=0, ready_o=0, done_o=0, error_o=0.
  - FIFO emptied.
  - All rf entries 0; data_o = 0.
  - Pending responses discarded.
- Operation resumes on the first clock after reset deasserts.
- en_i low: ready_o=0; responses already queued continue to drain.

Test Plan:
- Reset, then WRITE addr 3 data 0xDEADBEEF, then READ addr 3 -> one response, data_o = {4'h0, 4'h1, 4'h1, 8'h03, 0, 32'hDEADBEEF}, v_o one cycle after READ accept.
- ADD addr 5 data 0xFFFFFFFF twice after WRITE addr 5 data 2 -> responses 0x00000001 then 0x00000000 (wrap), in order.
- yumi_i held 0, send 3 ECHO packets (0x11, 0x22, 0x33) -> two accepted; ready_o=0 with count 2. Pulse yumi_i -> 0x11 popped; third accepted next cycle. Final order 0x11, 0x22, 0x33.
- READ addr 20 (els_p=16) and op 9 -> error_o=1; READ response data 0; op 9 produces no response; rf unchanged.
- Packet with dest 4'h7 -> consumed (ready_o=1), no v_o, error_o stays 0. Then FINISH -> done_o=1 next cycle, no response.
- Assert reset_i asynchronously with 2 queued responses and rf[3]=0xDEADBEEF -> v_o drops immediately; after reset, READ addr 3 returns 0.
